// File: rtl/axil_arbiter_mux_rd.sv
// AXI-Lite read arbiter/mux: N upstream masters share one downstream slave port.
// One read is outstanding at a time; the grant is held from AR acceptance until the R handshake.
module axil_arbiter_mux_rd #(
   parameter int unsigned NUMBER_MASTER = 2,
   parameter int unsigned ADDR_WIDTH    = 32,
   parameter int unsigned DATA_WIDTH    = 32,
   parameter int unsigned ROUND_ROBIN   = 0
) (
   input  logic                                  aclk,
   input  logic                                  areset,
   input  logic [NUMBER_MASTER*ADDR_WIDTH-1:0]   s_axil_araddr,
   input  logic [NUMBER_MASTER*3-1:0]            s_axil_arprot,
   input  logic [NUMBER_MASTER-1:0]              s_axil_arvalid,
   output logic [NUMBER_MASTER-1:0]              s_axil_arready,
   output logic [NUMBER_MASTER*DATA_WIDTH-1:0]   s_axil_rdata,
   output logic [NUMBER_MASTER*2-1:0]            s_axil_rresp,
   output logic [NUMBER_MASTER-1:0]              s_axil_rvalid,
   input  logic [NUMBER_MASTER-1:0]              s_axil_rready,
   output logic [ADDR_WIDTH-1:0]                 m_axil_araddr,
   output logic [2:0]                            m_axil_arprot,
   output logic                                  m_axil_arvalid,
   input  logic                                  m_axil_arready,
   input  logic [DATA_WIDTH-1:0]                 m_axil_rdata,
   input  logic [1:0]                            m_axil_rresp,
   input  logic                                  m_axil_rvalid,
   output logic                                  m_axil_rready,
   output logic [$clog2(NUMBER_MASTER)-1:0]      grant_rd,
   output logic                                  busy_rd
);

   localparam int unsigned GW = $clog2(NUMBER_MASTER);

   typedef enum logic [1:0] {StIdle, StAddr, StData} state_e;

   state_e          r_state, w_state_next;
   logic [GW-1:0]   r_grant, w_grant_next;
   logic [GW-1:0]   r_last_grant, w_last_grant_next;

   logic [GW-1:0]   w_lo, w_hi, w_sel;
   logic            w_lo_found, w_hi_found;

   // Request selection: lowest requester overall, and lowest requester above the last grant (RR).
   always_comb begin
      w_lo       = '0;
      w_hi       = '0;
      w_lo_found = 1'b0;
      w_hi_found = 1'b0;
      for (int i = 0; i < NUMBER_MASTER; i++) begin
         if (s_axil_arvalid[i] && !w_lo_found) begin
            w_lo       = GW'(i);
            w_lo_found = 1'b1;
         end
         if (s_axil_arvalid[i] && !w_hi_found && (GW'(i) > r_last_grant)) begin
            w_hi       = GW'(i);
            w_hi_found = 1'b1;
         end
      end
      // Round-robin wraps to the lowest requester when none lies above the last grant.
      w_sel = (ROUND_ROBIN != 0 && w_hi_found) ? w_hi : w_lo;
   end

   // FSM next state and grant bookkeeping.
   always_comb begin
      w_state_next      = r_state;
      w_grant_next      = r_grant;
      w_last_grant_next = r_last_grant;
      unique case (r_state)
         StIdle: begin
            if (|s_axil_arvalid) begin
               w_grant_next = w_sel;
               w_state_next = StAddr;
            end
         end
         StAddr: begin
            if (m_axil_arvalid && m_axil_arready) w_state_next = StData;
         end
         StData: begin
            if (m_axil_rvalid && m_axil_rready) begin
               w_state_next      = StIdle;
               w_last_grant_next = r_grant;
            end
         end
         default: w_state_next = StIdle;
      endcase
   end

   // State registers with synchronous reset; an in-flight read is simply abandoned.
   always_ff @(posedge aclk) begin
      if (areset) begin
         r_state      <= StIdle;
         r_grant      <= '0;
         r_last_grant <= GW'(NUMBER_MASTER - 1);
      end else begin
         r_state      <= w_state_next;
         r_grant      <= w_grant_next;
         r_last_grant <= w_last_grant_next;
      end
   end

   // Handshake routing and data muxing, all steered by the registered grant.
   always_comb begin
      s_axil_arready = '0;
      s_axil_rvalid  = '0;
      s_axil_rdata   = '0;
      s_axil_rresp   = '0;
      m_axil_araddr  = '0;
      m_axil_arprot  = '0;
      m_axil_arvalid = 1'b0;
      m_axil_rready  = 1'b0;
      for (int i = 0; i < NUMBER_MASTER; i++) begin
         if (GW'(i) == r_grant) begin
            m_axil_araddr                         = s_axil_araddr[i*ADDR_WIDTH +: ADDR_WIDTH];
            m_axil_arprot                         = s_axil_arprot[i*3 +: 3];
            s_axil_rdata[i*DATA_WIDTH +: DATA_WIDTH] = m_axil_rdata;
            s_axil_rresp[i*2 +: 2]                = m_axil_rresp;
            if (r_state == StAddr) begin
               m_axil_arvalid    = s_axil_arvalid[i];
               s_axil_arready[i] = m_axil_arready;
            end
            if (r_state == StData) begin
               m_axil_rready    = s_axil_rready[i];
               s_axil_rvalid[i] = m_axil_rvalid;
            end
         end
      end
   end

   assign grant_rd = r_grant;
   assign busy_rd  = (r_state != StIdle);

endmodule

// File: tb/tb_axil_arbiter_mux_rd.sv
// Directed bench: fixed-priority N=2 instance plus a round-robin N=4 instance on a shared reset.
module tb_axil_arbiter_mux_rd;

   logic clk = 1'b0;
   logic areset;
   int   n_tests = 0;
   int   n_fail  = 0;

   always #5 clk = ~clk;

   // Fixed-priority instance (N=2)
   logic [63:0] f_araddr;
   logic [5:0]  f_arprot;
   logic [1:0]  f_arvalid, f_arready, f_rvalid, f_rready;
   logic [63:0] f_rdata;
   logic [3:0]  f_rresp;
   logic [31:0] f_m_araddr, f_m_rdata;
   logic [2:0]  f_m_arprot;
   logic        f_m_arvalid, f_m_arready, f_m_rvalid, f_m_rready;
   logic [1:0]  f_m_rresp;
   logic [0:0]  f_grant;
   logic        f_busy;

   // Round-robin instance (N=4)
   logic [127:0] r_araddr;
   logic [11:0]  r_arprot;
   logic [3:0]   r_arvalid, r_arready, r_rvalid, r_rready;
   logic [127:0] r_rdata;
   logic [7:0]   r_rresp;
   logic [31:0]  r_m_araddr, r_m_rdata;
   logic [2:0]   r_m_arprot;
   logic         r_m_arvalid, r_m_arready, r_m_rvalid, r_m_rready;
   logic [1:0]   r_m_rresp;
   logic [1:0]   r_grant;
   logic         r_busy;

   axil_arbiter_mux_rd #(
      .NUMBER_MASTER(2), .ADDR_WIDTH(32), .DATA_WIDTH(32), .ROUND_ROBIN(0)
   ) u_fix (
      .aclk(clk), .areset(areset),
      .s_axil_araddr(f_araddr), .s_axil_arprot(f_arprot), .s_axil_arvalid(f_arvalid),
      .s_axil_arready(f_arready), .s_axil_rdata(f_rdata), .s_axil_rresp(f_rresp),
      .s_axil_rvalid(f_rvalid), .s_axil_rready(f_rready),
      .m_axil_araddr(f_m_araddr), .m_axil_arprot(f_m_arprot), .m_axil_arvalid(f_m_arvalid),
      .m_axil_arready(f_m_arready), .m_axil_rdata(f_m_rdata), .m_axil_rresp(f_m_rresp),
      .m_axil_rvalid(f_m_rvalid), .m_axil_rready(f_m_rready),
      .grant_rd(f_grant), .busy_rd(f_busy)
   );

   axil_arbiter_mux_rd #(
      .NUMBER_MASTER(4), .ADDR_WIDTH(32), .DATA_WIDTH(32), .ROUND_ROBIN(1)
   ) u_rr (
      .aclk(clk), .areset(areset),
      .s_axil_araddr(r_araddr), .s_axil_arprot(r_arprot), .s_axil_arvalid(r_arvalid),
      .s_axil_arready(r_arready), .s_axil_rdata(r_rdata), .s_axil_rresp(r_rresp),
      .s_axil_rvalid(r_rvalid), .s_axil_rready(r_rready),
      .m_axil_araddr(r_m_araddr), .m_axil_arprot(r_m_arprot), .m_axil_arvalid(r_m_arvalid),
      .m_axil_arready(r_m_arready), .m_axil_rdata(r_m_rdata), .m_axil_rresp(r_m_rresp),
      .m_axil_rvalid(r_m_rvalid), .m_axil_rready(r_m_rready),
      .grant_rd(r_grant), .busy_rd(r_busy)
   );

   // Advance to just after the next rising edge; inputs change here, checks follow #1 later.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      areset = 1'b1;
      f_arvalid = 2'b11;
      r_arvalid = 4'hF;
      tick();
      tick();
      #1;
      n_tests++;
      if ({f_arready, f_rvalid, f_m_arvalid, f_m_rready} !== 6'b0) begin
         n_fail++;
         $display("FAIL reset_fix_handshakes got %b want 0",
                  {f_arready, f_rvalid, f_m_arvalid, f_m_rready});
      end
      n_tests++;
      if ({f_grant, f_busy} !== 2'b00) begin
         n_fail++;
         $display("FAIL reset_fix_grant_busy got %b want 00", {f_grant, f_busy});
      end
      n_tests++;
      if ({r_arready, r_rvalid, r_m_arvalid, r_m_rready, r_grant, r_busy} !== 13'b0) begin
         n_fail++;
         $display("FAIL reset_rr_outputs got %b want 0",
                  {r_arready, r_rvalid, r_m_arvalid, r_m_rready, r_grant, r_busy});
      end
      f_arvalid = 2'b00;
      r_arvalid = 4'h0;
      areset = 1'b0;
      tick();
   endtask

   task automatic test_single_read();
      f_araddr  = {32'h0000_0040, 32'h0000_1234};
      f_arprot  = {3'b101, 3'b010};
      f_arvalid = 2'b10;
      tick();                                   // now ADDR, granted M1
      #1;
      n_tests++;
      if ({f_busy, f_grant, f_m_arvalid} !== 3'b111 || f_m_araddr !== 32'h40 ||
          f_m_arprot !== 3'b101) begin
         n_fail++;
         $display("FAIL single_addr busy/grant/arvalid=%b addr=%h prot=%b want 111 00000040 101",
                  {f_busy, f_grant, f_m_arvalid}, f_m_araddr, f_m_arprot);
      end
      tick();
      tick();                                   // slave still not ready after 2 cycles
      #1;
      n_tests++;
      if (f_m_arvalid !== 1'b1 || f_arready !== 2'b00) begin
         n_fail++;
         $display("FAIL single_wait arvalid=%b arready=%b want 1 00", f_m_arvalid, f_arready);
      end
      f_m_arready = 1'b1;
      #1;
      n_tests++;
      if (f_arready !== 2'b10) begin
         n_fail++;
         $display("FAIL single_arready got %b want 10", f_arready);
      end
      tick();                                   // now DATA
      f_arvalid   = 2'b00;
      f_m_arready = 1'b0;
      f_m_rvalid  = 1'b1;
      f_m_rdata   = 32'hDEAD_BEEF;
      f_m_rresp   = 2'b00;
      f_rready    = 2'b11;
      #1;
      n_tests++;
      if (f_rvalid !== 2'b10 || f_rdata !== {32'hDEAD_BEEF, 32'h0} || f_m_rready !== 1'b1) begin
         n_fail++;
         $display("FAIL single_rdata rvalid=%b rdata=%h rready=%b want 10 deadbeef00000000 1",
                  f_rvalid, f_rdata, f_m_rready);
      end
      tick();                                   // back to IDLE
      f_m_rvalid = 1'b0;
      #1;
      n_tests++;
      if (f_busy !== 1'b0 || f_rvalid !== 2'b00 || f_grant !== 1'b1) begin
         n_fail++;
         $display("FAIL single_done busy=%b rvalid=%b grant=%b want 0 00 1",
                  f_busy, f_rvalid, f_grant);
      end
   endtask

   task automatic test_fixed_priority();
      f_arvalid = 2'b11;
      f_rready  = 2'b11;
      for (int n = 0; n < 3; n++) begin
         tick();                                // ADDR
         #1;
         n_tests++;
         if (f_grant !== 1'b0 || f_m_arvalid !== 1'b1 || f_m_araddr !== 32'h1234) begin
            n_fail++;
            $display("FAIL fixed_grant_%0d grant=%b arvalid=%b addr=%h want 0 1 00001234",
                     n, f_grant, f_m_arvalid, f_m_araddr);
         end
         f_m_arready = 1'b1;
         tick();                                // DATA
         f_m_arready = 1'b0;
         f_m_rvalid  = 1'b1;
         tick();                                // IDLE
         f_m_rvalid  = 1'b0;
      end
      f_arvalid = 2'b10;                        // M0 stops requesting, M1 finally served
      tick();
      #1;
      n_tests++;
      if (f_grant !== 1'b1) begin
         n_fail++;
         $display("FAIL fixed_m1_after_m0 grant=%b want 1", f_grant);
      end
      f_m_arready = 1'b1;
      tick();
      f_arvalid   = 2'b00;
      f_m_arready = 1'b0;
      f_m_rvalid  = 1'b1;
      tick();
      f_m_rvalid  = 1'b0;
   endtask

   task automatic test_round_robin();
      logic [1:0] exp_order [5];
      exp_order = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
      r_araddr  = {32'h300, 32'h200, 32'h100, 32'h000};
      r_arvalid = 4'hF;
      r_rready  = 4'hF;
      for (int n = 0; n < 5; n++) begin
         tick();                                // ADDR
         #1;
         n_tests++;
         if (r_grant !== exp_order[n] || r_m_araddr !== {22'd0, exp_order[n], 8'h00}) begin
            n_fail++;
            $display("FAIL rr_grant_%0d grant=%0d addr=%h want %0d", n, r_grant, r_m_araddr,
                     exp_order[n]);
         end
         r_m_arready = 1'b1;
         tick();                                // DATA
         r_m_arready = 1'b0;
         r_m_rvalid  = 1'b1;
         r_m_rdata   = 32'hA000 + 32'(n);
         #1;
         n_tests++;
         if (r_rvalid !== (4'b0001 << exp_order[n])) begin
            n_fail++;
            $display("FAIL rr_rvalid_%0d got %b want one-hot %0d", n, r_rvalid, exp_order[n]);
         end
         tick();                                // IDLE between reads
         r_m_rvalid = 1'b0;
         #1;
         n_tests++;
         if (r_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL rr_idle_gap_%0d busy=%b want 0", n, r_busy);
         end
      end
      r_arvalid = 4'h0;
      tick();
   endtask

   task automatic test_backpressure();
      f_arvalid = 2'b01;
      tick();                                   // ADDR
      f_m_arready = 1'b1;
      tick();                                   // DATA
      f_arvalid   = 2'b10;                      // non-granted request must not disturb
      f_m_arready = 1'b0;
      f_m_rvalid  = 1'b1;
      f_rready    = 2'b10;
      for (int n = 0; n < 5; n++) begin
         #1;
         n_tests++;
         if (f_m_rready !== 1'b0 || f_busy !== 1'b1 || f_grant !== 1'b0 || f_rvalid !== 2'b01)
         begin
            n_fail++;
            $display("FAIL bp_hold_%0d rready=%b busy=%b grant=%b rvalid=%b want 0 1 0 01",
                     n, f_m_rready, f_busy, f_grant, f_rvalid);
         end
         tick();
      end
      f_rready = 2'b11;
      #1;
      n_tests++;
      if (f_m_rready !== 1'b1) begin
         n_fail++;
         $display("FAIL bp_release rready=%b want 1", f_m_rready);
      end
      tick();                                   // IDLE
      f_m_rvalid = 1'b0;
      f_arvalid  = 2'b00;
      #1;
      n_tests++;
      if (f_busy !== 1'b0) begin
         n_fail++;
         $display("FAIL bp_done busy=%b want 0", f_busy);
      end
   endtask

   task automatic test_reset_in_data();
      f_arvalid = 2'b10;
      tick();                                   // ADDR
      f_m_arready = 1'b1;
      tick();                                   // DATA
      f_arvalid   = 2'b00;
      f_m_arready = 1'b0;
      areset      = 1'b1;
      tick();
      areset      = 1'b0;
      f_m_rvalid  = 1'b1;                       // stray R outside DATA must be ignored
      #1;
      n_tests++;
      if (f_busy !== 1'b0 || f_grant !== 1'b0 || f_m_rready !== 1'b0 || f_rvalid !== 2'b00) begin
         n_fail++;
         $display("FAIL rst_data busy=%b grant=%b rready=%b rvalid=%b want 0 0 0 00",
                  f_busy, f_grant, f_m_rready, f_rvalid);
      end
      tick();
      f_m_rvalid = 1'b0;
      f_arvalid  = 2'b10;
      tick();                                   // ADDR for M1
      f_m_arready = 1'b1;
      #1;
      n_tests++;
      if (f_grant !== 1'b1 || f_arready !== 2'b10) begin
         n_fail++;
         $display("FAIL rst_regrant grant=%b arready=%b want 1 10", f_grant, f_arready);
      end
      tick();                                   // DATA
      f_arvalid   = 2'b00;
      f_m_arready = 1'b0;
      f_m_rvalid  = 1'b1;
      f_m_rdata   = 32'h0000_55AA;
      f_m_rresp   = 2'b10;
      #1;
      n_tests++;
      if (f_rdata !== {32'h55AA, 32'h0} || f_rresp !== 4'b1000 || f_rvalid !== 2'b10) begin
         n_fail++;
         $display("FAIL rst_complete rdata=%h rresp=%b rvalid=%b want 000055aa00000000 1000 10",
                  f_rdata, f_rresp, f_rvalid);
      end
      tick();
      f_m_rvalid = 1'b0;
      #1;
      n_tests++;
      if (f_busy !== 1'b0) begin
         n_fail++;
         $display("FAIL rst_complete_idle busy=%b want 0", f_busy);
      end
   endtask

   initial begin
      areset = 1'b1;
      f_araddr = '0; f_arprot = '0; f_arvalid = '0; f_rready = '0;
      f_m_arready = 1'b0; f_m_rdata = '0; f_m_rresp = '0; f_m_rvalid = 1'b0;
      r_araddr = '0; r_arprot = '0; r_arvalid = '0; r_rready = '0;
      r_m_arready = 1'b0; r_m_rdata = '0; r_m_rresp = '0; r_m_rvalid = 1'b0;
      test_reset();
      test_single_read();
      test_fixed_priority();
      test_round_robin();
      test_backpressure();
      test_reset_in_data();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
